// File: rtl/uart_tx_ctrl_if.sv
// TX FIFO read port as seen by the UART transmit sequencer.
//  fifo_empty  FIFO empty flag
//  fifo_data   first-word-fall-through head word, valid while fifo_empty=0
//  fifo_rd     pop strobe, one cycle per byte
// master: the sequencer that pops; slave: the FIFO that supplies data.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer. Pops bytes from the FWFT TX FIFO and serialises
// them onto txd: start bit, 5..8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Bit timing is OVS baud_tick pulses per bit.
//  wclk        system clock (shared with the TX FIFO)
//  rst_n       asynchronous active-low reset
//  baud_tick   1-cycle strobe at OVS x baud rate
//  tx_en       allow new frames to start
//  data_len    00=5, 01=6, 10=7, 11=8 data bits
//  parity_en   append parity bit; parity_odd selects odd parity
//  stop2       two stop bits
//  brk         force txd low (sequencer keeps running)
//  fifo        TX FIFO read port (empty / head data / pop strobe)
//  txd         registered serial output, idle high
//  tx_busy     high in any state other than IDLE
//  tx_done     1-cycle pulse at the end of the last stop bit
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OVS        = 16
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic                  tx_en,
  input  logic [1:0]            data_len,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  input  logic                  brk,
  uart_tx_ctrl_if.master        fifo,
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tick_cnt;
  logic [2:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_acc;
  logic [1:0]            len_l;
  logic                  par_en_l;
  logic                  par_odd_l;
  logic                  stop2_l;

  logic                  bit_end;
  logic                  can_pop;
  logic                  frame_end;
  logic                  load;
  logic                  line;
  logic [2:0]            last_bit;

  assign bit_end  = baud_tick && (tick_cnt == TICK_LAST);
  assign can_pop  = tx_en && !fifo.fifo_empty;
  assign last_bit = {1'b0, len_l} + 3'd4;
  assign tx_busy  = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    frame_end = 1'b0;
    line      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (can_pop && baud_tick) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        line = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        line = shreg[0];
        if (bit_end && (bit_cnt == last_bit))
          state_d = par_en_l ? S_PARITY : S_STOP1;
      end
      S_PARITY: begin
        line = par_acc ^ par_odd_l;
        if (bit_end) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (bit_end) begin
          if (stop2_l) state_d = S_STOP2;
          else         frame_end = 1'b1;
        end
      end
      S_STOP2: begin
        if (bit_end) frame_end = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Back-to-back frames: pop at the final stop-bit edge and relaunch
    // without passing through IDLE.
    if (frame_end) begin
      if (can_pop) begin
        load    = 1'b1;
        state_d = S_START;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State is IDLE while reset is held, so gating with rst_n keeps the pop
  // strobe quiet during reset even if the FIFO has data and a tick arrives.
  assign fifo.fifo_rd = load && rst_n;
  assign tx_done      = frame_end;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      txd       <= 1'b1;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      len_l     <= '0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      stop2_l   <= 1'b0;
    end else begin
      txd <= brk ? 1'b0 : line;
      if (load) begin
        shreg     <= fifo.fifo_data;
        len_l     <= data_len;
        par_en_l  <= parity_en;
        par_odd_l <= parity_odd;
        stop2_l   <= stop2;
        tick_cnt  <= '0;
        bit_cnt   <= '0;
        par_acc   <= 1'b0;
      end else if ((state_q != S_IDLE) && baud_tick) begin
        if (bit_end) begin
          tick_cnt <= '0;
          if (state_q == S_START) bit_cnt <= '0;
          if (state_q == S_DATA) begin
            // Parity accumulates only the bits actually shifted out.
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            par_acc <= par_acc ^ shreg[0];
          end
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
    end
  end

endmodule
